// File: rtl/uart_tx_pkg.sv
// Shared definitions for the serial console transmitter: bus addresses,
// STATUS bit positions and the transmit FSM state encoding.
package uart_tx_pkg;

  localparam logic [63:0] UART_TXDATA_ADDR = 64'hb000_0010;
  localparam logic [63:0] UART_STATUS_ADDR = 64'hb000_0018;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one-extra-bit pointers for full/empty detection.
// A pop is taken only when non-empty; a push is taken when not full, or
// when a pop on the same edge frees the slot being written.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; pointers wrap modulo 2*DEPTH through natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 transmitter: bus writes queue bytes into a FIFO, the
// FSM shifts them out LSB first with CLK_DIV clocks per bit. Frames that
// are already queued follow each other with no idle gap.
//
// Bus handshake: there is no ready/stall. A TXDATA write is a push request
// that is accepted on the sampling edge if the FIFO has room or the FSM pops
// on that same edge; otherwise the byte is dropped and sticky ovf records it.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wen,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata,
  input  logic        ren,
  input  logic [63:0] raddr,
  output logic [63:0] rdata,
  output logic        tx,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  uart_tx_state_e state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;
  logic        pop;
  logic        ovf;
  logic        wr_txdata;
  logic        wr_status;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [63:0] status;
  logic        unused_wdata;

  assign wr_txdata    = wen && (waddr == UART_TXDATA_ADDR);
  assign wr_status    = wen && (waddr == UART_STATUS_ADDR);
  assign unused_wdata = ^wdata[63:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // STATUS read mux; anything other than a STATUS read returns zero.
  always_comb begin
    status                   = '0;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_BUSY_BIT]  = (state != IDLE);
    status[STATUS_OVF_BIT]   = ovf;
    rdata = (ren && (raddr == UART_STATUS_ADDR)) ? status : 64'b0;
  end

  // Sticky overflow: a dropped push sets it, a STATUS write of bit 3 clears
  // it, and a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (wr_txdata && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else if (wr_status && wdata[STATUS_OVF_BIT]) begin
      ovf <= 1'b0;
    end
  end

  // FSM, baud counter, bit index, shift and tx registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // Next state; tx_n is the line level belonging to the next state so tx
  // changes on the same edge as the state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = DIV_M1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          cnt_n     = DIV_M1;
          tx_n      = shift[0];
        end else begin
          cnt_n = cnt - 16'd1;
          tx_n  = 1'b0;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = DIV_M1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
          tx_n  = shift[0];
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            cnt_n   = DIV_M1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
          tx_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLK_DIV = 4, FIFO_DEPTH = 4. Expected bytes are
// queued when written; a monitor decodes frames from tx and pops/compares.
module tb_uart_tx;

  localparam logic [63:0] TXDATA = 64'hb000_0010;
  localparam logic [63:0] STATUS = 64'hb000_0018;

  logic        clk;
  logic        rstn;
  logic        wen;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic        ren;
  logic [63:0] raddr;
  logic [63:0] rdata;
  logic        tx;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  // Monitor state
  logic       mon_active = 1'b0;
  int         mon_pos    = 0;
  logic [7:0] mon_byte   = '0;

  uart_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .ren       (ren),
    .raddr     (raddr),
    .rdata     (rdata),
    .tx        (tx),
    .dbg_state (dbg_state)
  );

  // Clock and edge counter: after posedge n, cyc == n.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    wen   = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input logic en, output logic [63:0] d);
    ren   = en;
    raddr = a;
    #1;
    d     = rdata;
    ren   = 1'b0;
    raddr = '0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame monitor: samples tx on the falling edge, checks every bit cell is
  // held for 4 cycles, then compares the byte against the expected queue.
  always @(negedge clk or negedge rstn) begin
    int b;
    logic [7:0] e;
    if (!rstn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 1;
        start_q.push_back(cyc);
      end
    end else begin
      b = mon_pos / 4;
      if (b == 0) chk("start_bit", 64'(tx), 64'd0);
      else if (b <= 8) begin
        if (mon_pos % 4 == 0) mon_byte[b-1] = tx;
        else chk("data_bit_hold", 64'(tx), 64'(mon_byte[b-1]));
      end else chk("stop_bit", 64'(tx), 64'd1);
      if (mon_pos == 39) begin
        mon_active = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_frame", 64'(mon_byte), 64'hx_dead);
        else begin
          e = exp_q.pop_front();
          chk("frame_byte", 64'(mon_byte), 64'(e));
        end
      end else begin
        mon_pos++;
      end
    end
  end

  initial begin
    logic [63:0] d;
    int base;
    int w;
    int s;
    int n0;
    rstn  = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    #22 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    rd(STATUS, 1'b1, d);  chk("status_after_reset", d, 64'h2);
    rd(STATUS, 1'b0, d);  chk("status_ren_low", d, 64'h0);
    chk("tx_after_reset", 64'(tx), 64'd1);
    chk("state_after_reset", 64'(dbg_state), 64'd0);

    // Single byte 0x55 written at edge 10
    wait_cyc(9);
    wr(TXDATA, 64'hffff_ffff_ffff_ff55);
    exp_q.push_back(8'h55);
    wait_cyc(50);
    rd(STATUS, 1'b1, d);  chk("status_stop_bit", d, 64'h6);
    wait_cyc(51);
    rd(STATUS, 1'b1, d);  chk("status_idle_edge51", d, 64'h2);
    chk("tx_idle_edge51", 64'(tx), 64'd1);
    chk("start_edge", 64'(start_q[0]), 64'd11);
    chk("frame55_done", 64'(exp_q.size()), 64'd0);

    // Two back-to-back frames
    base = start_q.size();
    wr(TXDATA, 64'hA5);
    wr(TXDATA, 64'h3C);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wait_cyc(cyc + 85);
    chk("b2b_frames", 64'(start_q.size() - base), 64'd2);
    chk("b2b_gap", 64'(start_q[base+1] - start_q[base]), 64'd40);
    chk("b2b_done", 64'(exp_q.size()), 64'd0);

    // Six writes while idle: one popped, four queued, sixth dropped
    base = start_q.size();
    wr(TXDATA, 64'h11);
    w = cyc;
    wr(TXDATA, 64'h22);
    wr(TXDATA, 64'h33);
    wr(TXDATA, 64'h44);
    wr(TXDATA, 64'h66);
    wr(TXDATA, 64'h77);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h66);
    rd(STATUS, 1'b1, d);  chk("status_full_ovf", d, 64'hD);
    wr(STATUS, 64'h8);
    rd(STATUS, 1'b1, d);  chk("status_ovf_cleared", d, 64'h5);

    // Push on the edge the first STOP bit ends while full
    wait_cyc(w + 40);
    rd(STATUS, 1'b1, d);  chk("status_full_before_stop_end", d, 64'h5);
    wr(TXDATA, 64'h88);
    exp_q.push_back(8'h88);
    rd(STATUS, 1'b1, d);  chk("status_push_pop_full", d, 64'h5);

    wait_cyc(w + 250);
    chk("burst_frames", 64'(start_q.size() - base), 64'd6);
    for (int i = 1; i < 6; i++) begin
      if (base + i < start_q.size())
        chk("burst_gap", 64'(start_q[base+i] - start_q[base+i-1]), 64'd40);
    end
    chk("burst_done", 64'(exp_q.size()), 64'd0);
    rd(STATUS, 1'b1, d);  chk("status_after_burst", d, 64'h2);

    // Address decode
    rd(STATUS, 1'b0, d);              chk("rd_status_ren0", d, 64'h0);
    rd(64'hb000_0000, 1'b1, d);       chk("rd_other_addr", d, 64'h0);
    rd(TXDATA, 1'b1, d);              chk("rd_txdata", d, 64'h0);
    base = start_q.size();
    wr(64'hb000_0020, 64'h99);
    wr(STATUS, 64'hff);
    wait_cyc(cyc + 10);
    chk("ignored_write_frames", 64'(start_q.size() - base), 64'd0);
    rd(STATUS, 1'b1, d);              chk("status_after_ignored", d, 64'h2);

    // Reset during data bit 3 of 0x00
    wr(TXDATA, 64'h00);
    exp_q.push_back(8'h00);
    s = cyc + 1;
    wait_cyc(s + 17);
    #2;
    rstn = 1'b0;
    #1;
    chk("tx_async_reset", 64'(tx), 64'd1);
    exp_q.delete();
    n0 = start_q.size();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    rd(STATUS, 1'b1, d);  chk("status_after_abort", d, 64'h2);
    chk("state_after_abort", 64'(dbg_state), 64'd0);
    wait_cyc(cyc + 60);
    chk("no_frame_after_abort", 64'(start_q.size() - n0), 64'd0);
    chk("tx_idle_after_abort", 64'(tx), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
